// File: rtl/mem_arbiter.sv
// mem_arbiter
// Two-port round-robin arbiter and sequencer for a shared negedge-clocked
// BRAM. Port 0 is the processor data path and port 1 is the ROM loader/debug
// path. Each granted request becomes exactly one Memory transaction:
// IDLE -> ACCESS (one cycle, Memory acts on the intervening negedge) ->
// ACK (one-cycle ack pulse) -> IDLE.
//
// Ports:
//   clk_i       system clock (this block on posedge, Memory on negedge)
//   reset_ni    asynchronous active-low reset
//   req_i       per-port request, held until that port's ack_o pulses
//   pN_we_i     1 = write, 0 = read
//   pN_addr_i   access address
//   pN_data_i   write data
//   ack_o       one-cycle completion pulse per port
//   gnt_o       one-hot owner of the current transaction, 0 when idle
//   rdata_o     registered read data, valid while ack_o is high for a read
//   busy_o      high in ACCESS and ACK
//   mem_addr_o  Memory address
//   mem_data_o  Memory write data
//   mem_we_no   Memory write enable, active low
//   mem_data_i  Memory read data
module mem_arbiter #(
  parameter int WORDS      = 8,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic [1:0]            req_i,
  input  logic                  p0_we_i,
  input  logic                  p1_we_i,
  input  logic [WORDS-1:0]      p0_addr_i,
  input  logic [WORDS-1:0]      p1_addr_i,
  input  logic [DATA_WIDTH-1:0] p0_data_i,
  input  logic [DATA_WIDTH-1:0] p1_data_i,
  output logic [1:0]            ack_o,
  output logic [1:0]            gnt_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  busy_o,
  output logic [WORDS-1:0]      mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_data_o,
  output logic                  mem_we_no,
  input  logic [DATA_WIDTH-1:0] mem_data_i
);

  typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

  state_t                state_q, state_d;
  logic                  last_q, last_d;   // port that won the previous grant
  logic                  win_q, win_d;     // owner of the current transaction
  logic                  we_q, we_d;       // current transaction is a write
  logic [1:0]            gnt_q, gnt_d;
  logic [1:0]            ack_q, ack_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [WORDS-1:0]      addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  we_n_q, we_n_d;
  logic                  win_sel;
  logic                  win_we;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    win_d   = win_q;
    we_d    = we_q;
    gnt_d   = gnt_q;
    ack_d   = ack_q;
    rdata_d = rdata_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_n_d  = we_n_q;

    // A lone request wins outright; on a tie the port that did not win last
    // time goes next, so neither port waits more than one transaction.
    case (req_i)
      2'b01:   win_sel = 1'b0;
      2'b10:   win_sel = 1'b1;
      default: win_sel = ~last_q;
    endcase
    win_we = win_sel ? p1_we_i : p0_we_i;

    case (state_q)
      IDLE: begin
        if (|req_i) begin
          state_d = ACCESS;
          win_d   = win_sel;
          last_d  = win_sel;
          we_d    = win_we;
          we_n_d  = ~win_we;
          gnt_d   = win_sel ? 2'b10 : 2'b01;
          addr_d  = win_sel ? p1_addr_i : p0_addr_i;
          wdata_d = win_sel ? p1_data_i : p0_data_i;
        end
      end
      ACCESS: begin
        // The Memory has acted on the negedge inside this cycle.
        state_d = ACK;
        we_n_d  = 1'b1;
        if (!we_q) rdata_d = mem_data_i;
        ack_d   = win_q ? 2'b10 : 2'b01;
      end
      ACK: begin
        state_d = IDLE;
        ack_d   = 2'b00;
        gnt_d   = 2'b00;
      end
      default: begin
        state_d = IDLE;
        ack_d   = 2'b00;
        gnt_d   = 2'b00;
        we_n_d  = 1'b1;
      end
    endcase
  end

  // Reset asynchronously forces the write strobe inactive and aborts any
  // transaction in flight without an ack.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      win_q   <= 1'b0;
      we_q    <= 1'b0;
      gnt_q   <= 2'b00;
      ack_q   <= 2'b00;
      rdata_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      win_q   <= win_d;
      we_q    <= we_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_n_q  <= we_n_d;
    end
  end

  assign ack_o      = ack_q;
  assign gnt_o      = gnt_q;
  assign rdata_o    = rdata_q;
  assign busy_o     = (state_q == ACCESS) || (state_q == ACK);
  assign mem_addr_o = addr_q;
  assign mem_data_o = wdata_q;
  assign mem_we_no  = we_n_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioral negedge BRAM model.
// Memory is preloaded with mem[a] = {8'hA5, a}.
module tb_mem_arbiter;

  logic        clk;
  logic        reset_n;
  logic [1:0]  req;
  logic        p0_we, p1_we;
  logic [7:0]  p0_addr, p1_addr;
  logic [15:0] p0_data, p1_data;
  logic [1:0]  ack, gnt;
  logic [15:0] rdata;
  logic        busy;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we_n;
  logic [15:0] mem_rdata;

  logic [15:0] mem [0:255];
  int          total;
  int          bad;
  int          we_low;
  int          viol;

  mem_arbiter #(.WORDS(8), .DATA_WIDTH(16)) dut (
    .clk_i      (clk),
    .reset_ni   (reset_n),
    .req_i      (req),
    .p0_we_i    (p0_we),
    .p1_we_i    (p1_we),
    .p0_addr_i  (p0_addr),
    .p1_addr_i  (p1_addr),
    .p0_data_i  (p0_data),
    .p1_data_i  (p1_data),
    .ack_o      (ack),
    .gnt_o      (gnt),
    .rdata_o    (rdata),
    .busy_o     (busy),
    .mem_addr_o (mem_addr),
    .mem_data_o (mem_wdata),
    .mem_we_no  (mem_we_n),
    .mem_data_i (mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Negedge BRAM: registered read of the old word, write when strobe low.
  always @(negedge clk) begin
    mem_rdata = mem[mem_addr];
    if (mem_we_n === 1'b0) begin
      mem[mem_addr] = mem_wdata;
      we_low = we_low + 1;
      if (gnt === 2'b00 || ack !== 2'b00) viol = viol + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) else begin
      bad = bad + 1;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0]  eg;
    logic [15:0] ed;
    total = 0; bad = 0; we_low = 0; viol = 0;
    mem_rdata = 16'h0;
    for (int i = 0; i < 256; i++) mem[i] = {8'hA5, 8'(i)};
    req = 2'b00; p0_we = 0; p1_we = 0;
    p0_addr = 8'h00; p1_addr = 8'h00; p0_data = 16'h0; p1_data = 16'h0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    // reset state
    chk("rst_ack", ack, 2'b00);
    chk("rst_gnt", gnt, 2'b00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rdata", rdata, 16'h0);
    chk("rst_addr", mem_addr, 8'h00);
    chk("rst_wdata", mem_wdata, 16'h0);
    chk("rst_we_n", mem_we_n, 1'b1);
    step(); step();
    reset_n = 1'b1;

    // port 0 write BEEF to 10, then read it back
    req = 2'b01; p0_we = 1; p0_addr = 8'h10; p0_data = 16'hBEEF;
    step();
    chk("w_gnt", gnt, 2'b01);
    chk("w_we_n", mem_we_n, 1'b0);
    chk("w_addr", mem_addr, 8'h10);
    chk("w_data", mem_wdata, 16'hBEEF);
    chk("w_busy", busy, 1'b1);
    chk("w_ack0", ack, 2'b00);
    step();
    chk("w_ack", ack, 2'b01);
    chk("w_we_n_hi", mem_we_n, 1'b1);
    chk("w_rdata_hold", rdata, 16'h0);
    chk("w_low_cnt", we_low, 1);
    step();
    chk("w_ack_clr", ack, 2'b00);
    chk("w_gnt_clr", gnt, 2'b00);
    chk("w_idle", busy, 1'b0);
    p0_we = 0;
    step();
    chk("r_gnt", gnt, 2'b01);
    chk("r_we_n", mem_we_n, 1'b1);
    step();
    chk("r_ack", ack, 2'b01);
    chk("r_rdata", rdata, 16'hBEEF);
    step();
    req = 2'b00;

    // fresh reset, then both ports contend with reads
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    req = 2'b11; p0_we = 0; p0_addr = 8'h00; p1_we = 0; p1_addr = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      eg = (i % 2 == 0) ? 2'b01 : 2'b10;
      ed = (i % 2 == 0) ? 16'hA500 : 16'hA5FF;
      step();
      chk("rr_gnt", gnt, eg);
      chk("rr_ack0", ack, 2'b00);
      step();
      chk("rr_ack", ack, eg);
      chk("rr_rdata", rdata, ed);
      step();
      chk("rr_idle", ack, 2'b00);
    end

    // port 1 write 1234 to FF against port 0 read of FF, last winner port 1
    p1_we = 1; p1_data = 16'h1234; p1_addr = 8'hFF; p0_addr = 8'hFF;
    step();
    chk("c_gnt0", gnt, 2'b01);
    step();
    chk("c_ack0", ack, 2'b01);
    chk("c_rd_old", rdata, 16'hA5FF);
    step();
    step();
    chk("c_gnt1", gnt, 2'b10);
    chk("c_we_n", mem_we_n, 1'b0);
    chk("c_addr", mem_addr, 8'hFF);
    chk("c_data", mem_wdata, 16'h1234);
    step();
    chk("c_ack1", ack, 2'b10);
    chk("c_rd_hold", rdata, 16'hA5FF);
    req = 2'b01;
    step();
    step();
    chk("c_gnt0b", gnt, 2'b01);
    step();
    chk("c_ack0b", ack, 2'b01);
    chk("c_rd_new", rdata, 16'h1234);
    step();
    req = 2'b00;

    // address change after the grant does not affect the transaction
    p0_we = 0; p0_addr = 8'h02; req = 2'b01;
    step();
    chk("a_gnt", gnt, 2'b01);
    chk("a_addr", mem_addr, 8'h02);
    p0_addr = 8'h03;
    step();
    chk("a_ack", ack, 2'b01);
    chk("a_rdata", rdata, 16'hA502);
    chk("a_addr_hold", mem_addr, 8'h02);
    step();
    req = 2'b00;

    // reset asserted during a write access
    p0_we = 1; p0_addr = 8'h20; p0_data = 16'h5555; req = 2'b01;
    step();
    chk("x_we_n_lo", mem_we_n, 1'b0);
    #1 reset_n = 1'b0;
    #1;
    chk("x_we_n_hi", mem_we_n, 1'b1);
    chk("x_ack", ack, 2'b00);
    chk("x_gnt", gnt, 2'b00);
    chk("x_busy", busy, 1'b0);
    step(); step();
    chk("x_no_ack", ack, 2'b00);
    chk("x_mem_kept", mem[8'h20], 16'hA520);
    reset_n = 1'b1;
    step();
    chk("x_regnt", gnt, 2'b01);
    chk("x_rewe_n", mem_we_n, 1'b0);
    chk("x_readdr", mem_addr, 8'h20);
    step();
    chk("x_reack", ack, 2'b01);
    chk("x_mem_new", mem[8'h20], 16'h5555);
    step();
    req = 2'b00;

    // idle bus
    for (int i = 0; i < 10; i++) begin
      step();
      chk("i_busy", busy, 1'b0);
      chk("i_we_n", mem_we_n, 1'b1);
      chk("i_ack", ack, 2'b00);
    end

    chk("we_low_total", we_low, 3);
    chk("we_low_outside", viol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port round-robin arbiter and sequencer for the shared negedge-clocked BRAM Memory block (256x16 by default). It sits between two requesters and the Memory instance. Port 0 is the processor data path; port 1 is the ROM loader/debug path. It serializes their accesses into single Memory transactions, drives the Memory's address, data and active-low write enable, and returns registered read data with a one-cycle acknowledge. The block is clocked on the rising edge; the Memory samples on the falling edge of the same clock.

## Interface
Parameters:
- WORDS, 8, address width (Memory depth = 2^WORDS)
- DATA_WIDTH, 16, data word width

Ports:
- clk_i  input  1  system clock; block logic on posedge, Memory on negedge
- reset_ni  input  1  asynchronous, active-low reset
- req_i  input  2  per-port request; held high until that port's ack_o pulses
- p0_we_i / p1_we_i  input  1 each  1 = write, 0 = read; stable while req high
- p0_addr_i / p1_addr_i  input  WORDS each  access address
- p0_data_i / p1_data_i  input  DATA_WIDTH each  write data
- ack_o  output  2  one-cycle completion pulse per port
- gnt_o  output  2  one-hot owner of the current transaction; 0 when idle
- rdata_o  output  DATA_WIDTH  read data; valid while ack_o is high for a read
- busy_o  output  1  high in ACCESS and ACK states
- mem_addr_o  output  WORDS  to Memory address_i
- mem_data_o  output  DATA_WIDTH  to Memory data_i
- mem_we_no  output  1  to Memory write_en_ni (active low)
- mem_data_i  input  DATA_WIDTH  from Memory data_o

## Operation
- FSM states: IDLE, ACCESS, ACK. Reset state is IDLE.
- IDLE: if any req_i bit is high, select the winner, go to ACCESS. Otherwise stay in IDLE.
  - Only one request high: grant that port.
  - Both high: grant the port that is not last_gnt (round-robin).
- On the grant edge:
  - Register the winner's addr and data into mem_addr_o and mem_data_o.
  - Set mem_we_no = ~we of the winner.
  - Set gnt_o to the winner's one-hot bit.
  - Set last_gnt to the winner.
- ACCESS: lasts exactly one cycle; the Memory performs the read or write on the intervening negedge.
  - At the next posedge: mem_we_no goes high.
  - If the access was a read, capture mem_data_i into rdata_o. If it was a write, rdata_o holds its previous value.
  - Set ack_o[winner] = 1 and go to ACK.
- ACK: ack_o clears and gnt_o clears at the next posedge, then the FSM returns to IDLE unconditionally. Requests are not sampled in ACK.
- Requester rule: drop req_i (or present a new request) at the posedge that ends ACK. A req still high in IDLE is a new transaction.
- A write followed by a read of the same address returns the new data. The write completes before the read is issued.
- mem_addr_o and mem_data_o hold their last values when idle. Only mem_we_no gates writes.
- Changes to p*_addr, p*_data and p*_we after the grant edge have no effect on the current transaction.

## Timing
- Reset values:
  - state IDLE, last_gnt = 1 (port 0 wins the first tie)
  - ack_o = 0, gnt_o = 0, busy_o = 0, rdata_o = 0
  - mem_addr_o = 0, mem_data_o = 0, mem_we_no = 1
- Asserting reset_ni low mid-transaction forces mem_we_no high immediately (asynchronously) and aborts the transaction. No ack is issued.
- Latency: grant at edge E0, Memory access at the negedge between E0 and E1, ack_o high from E1 to E2, IDLE from E2.
- The earliest next grant is at E3 (a pending request is sampled at E3). Throughput is one access per 3 cycles under continuous load.
- Under contention with both ports continuously requesting, grants alternate 0,1,0,1. Neither port waits more than one transaction.
- mem_we_no is low for exactly one cycle (E0 to E1) per write. It is never low outside ACCESS.

## Test plan
- Port 0 writes 16'hBEEF to 8'h10, then reads 8'h10 -> mem_we_no low for exactly 1 cycle; read ack_o[0] with rdata_o = 16'hBEEF three cycles after the write ack.
- Both ports assert req_i = 2'b11 out of reset: port 0 reads 8'h00, port 1 reads 8'hFF -> port 0 granted first; ack_o sequence 01 then 10; grants alternate for 4 back-to-back transactions.
- Port 1 writes 16'h1234 to 8'hFF while port 0 holds req on a read of 8'hFF -> port 1 served only if last_gnt = 0; the read returns 16'h1234 when ordered after the write.
- Port 0 changes p0_addr_i from 8'h02 to 8'h03 one cycle after the grant -> the Memory sees 8'h02; rdata_o = mem[8'h02].
- Assert reset_ni low during ACCESS of a write -> mem_we_no goes high without waiting for a clock edge; ack_o = 0, gnt_o = 0, busy_o = 0; the next request after reset is granted normally.
- Idle bus with req_i = 0 for 10 cycles -> busy_o = 0, mem_we_no = 1, ack_o = 0 throughout.
